event_stream_encoder: RTL and testbench
=======================================

// Module: event_stream_encoder
// PURPOSE
//  Producer end of the 2-bit event interface (x, y, p, t). Accepts intensity samples from a 4x4
//  pixel array and keeps a per-pixel reference level. It emits an ON/OFF event when a pixel's change
//  reaches a threshold. Events are buffered in a small FIFO and presented with valid/ready.
//  Sits upstream of the event denoising filter and feeds its x/y/p/t inputs.
// PARAMETERS
//  THRESH      2   unsigned 4-bit change threshold; event when |pix_val - ref| >= THRESH
//  FIFO_DEPTH  4   event FIFO entries (power of 2, >= 2)
//  TS_DIV      8   clk cycles per timestamp tick (>= 1)
// PORTS
//  clk         in   1  system clock, all state on rising edge
//  rst_n       in   1  asynchronous, active-low reset
//  pix_valid   in   1  sample strobe; pix_x/pix_y/pix_val sampled when high
//  pix_x       in   2  pixel column
//  pix_y       in   2  pixel row
//  pix_val     in   4  unsigned pixel intensity
//  ev_valid    out  1  FIFO head valid
//  ev_ready    in   1  downstream accepts head when ev_valid && ev_ready
//  ev_x        out  2  head event column
//  ev_y        out  2  head event row
//  ev_p        out  2  polarity: 2'b11 ON (increase), 2'b10 OFF (decrease)
//  ev_t        out  2  timestamp captured at push
//  fifo_count  out  3  occupied entries, 0..FIFO_DEPTH
//  overflow    out  1  sticky: an event was dropped because the FIFO was full
//  clear_ovf   in   1  synchronous clear of overflow
// BEHAVIOUR
//  Reset (rst_n low, asynchronous): ev_valid=0, ev_x/ev_y/ev_p/ev_t=0, fifo_count=0, overflow=0.
//   All 16 ref=0 and seen=0. Timestamp=0, divider=0. Reset mid-operation discards queued events.
//  Timestamp: divider counts 0..TS_DIV-1 and increments t on the wrap. The 2-bit t wraps 3->0.
//  Sample at edge N with pix_valid=1, idx={pix_y,pix_x}:
//   - If seen[idx]=0: ref[idx]<=pix_val and seen[idx]<=1. No event.
//   - Else diff = pix_val - ref[idx], computed 5-bit signed with no wrap.
//     diff >= THRESH gives ON. -diff >= THRESH gives OFF. Otherwise no event and ref is unchanged.
//   - On an event, push {pix_x, pix_y, p, t_current} and set ref[idx]<=pix_val.
//  Overflow: a push attempted while full with no pop in the same cycle drops the event.
//   On a drop: ref[idx] is NOT updated and overflow<=1.
//  Push while full with a pop in the same cycle (ev_valid && ev_ready) succeeds; count is unchanged.
//  Pop while empty is ignored. Simultaneous push and pop on a non-empty FIFO leaves count unchanged.
//  Latency: an event pushed at edge N appears at the head with ev_valid=1 after edge N (cycle N+1)
//   if the FIFO was empty. Strict FIFO order.
//  ev_x/ev_y/ev_p/ev_t show the head entry while ev_valid=1 and are 0 when empty.
//   Head data holds stable while ev_valid && !ev_ready.
//  clear_ovf=1 clears overflow at the next edge. If a drop occurs in the same cycle, set wins.
//  pix_valid=0: no state change except the timestamp and the FIFO pop.
// TESTING
//  1. Reset, then sample (1,2,val=5) -> no event, fifo_count=0. Resample (1,2,7) -> next cycle
//     ev_valid=1, ev_x=1, ev_y=2, ev_p=2'b11.
//  2. Threshold edge: ref=7. Sample 6 -> no event. Sample 5 -> OFF event with ev_p=2'b10; ref becomes 5.
//  3. Hold ev_ready=0 and push 5 events -> fifo_count=4, overflow=1. The dropped pixel's ref is unchanged.
//     clear_ovf -> overflow=0.
//  4. FIFO full, push and pop in the same cycle -> fifo_count stays 4. Drain order matches push order.
//  5. TS_DIV=8: events at cycles 0, 9, 17 and 33 carry ev_t=0, 1, 2 and 0 (wrap).
//  6. rst_n low while 3 events are queued -> ev_valid=0 and fifo_count=0 immediately.
//     The first post-reset sample only seeds ref.

Source files
------------

// File: rtl/event_stream_encoder.sv
// Purpose : 4x4 pixel change detector; emits ON/OFF events (x, y, p, t) into a small FIFO.
// Latency : event pushed at edge N is at the head (ev_valid=1) after edge N when the FIFO was empty.
// Backpressure: valid/ready on the head; a push into a full FIFO with no pop is dropped and flags overflow.
// Ports: pix_valid/pix_x/pix_y/pix_val sample input; ev_valid/ev_ready/ev_x/ev_y/ev_p/ev_t event
//        output; fifo_count occupancy; overflow sticky drop flag cleared by clear_ovf.
module event_stream_encoder #(
  parameter logic [3:0] THRESH     = 4'd2,
  parameter int         FIFO_DEPTH = 4,
  parameter int         TS_DIV     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_valid,
  input  logic [1:0] pix_x,
  input  logic [1:0] pix_y,
  input  logic [3:0] pix_val,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [1:0] ev_x,
  output logic [1:0] ev_y,
  output logic [1:0] ev_p,
  output logic [1:0] ev_t,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  output logic       overflow,
  input  logic       clear_ovf
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam int DW = (TS_DIV > 1) ? $clog2(TS_DIV) : 1;
  localparam logic signed [4:0] THR5 = {1'b0, THRESH};

  typedef struct packed {
    logic [1:0] x;
    logic [1:0] y;
    logic [1:0] p;
    logic [1:0] t;
  } event_s;

  logic [DW-1:0]      div_cnt;
  logic [1:0]         ts;
  logic [15:0][3:0]   ref_lvl;
  logic [15:0]        seen;
  event_s             mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [CW-1:0]      count;

  logic [3:0]         idx;
  logic signed [4:0]  diff;
  logic               is_on;
  logic               is_off;
  logic               want_push;
  logic               pop;
  logic               full;
  logic               push_ok;
  logic               drop;
  logic [1:0]         pol;
  event_s             head;

  assign idx  = {pix_y, pix_x};
  // Both operands zero-extended to 5 bits so the difference never wraps.
  assign diff   = $signed({1'b0, pix_val}) - $signed({1'b0, ref_lvl[idx]});
  assign is_on  = (diff >= THR5);
  assign is_off = ((-diff) >= THR5);
  assign pol    = is_on ? 2'b11 : 2'b10;

  assign want_push = pix_valid && seen[idx] && (is_on || is_off);
  assign ev_valid  = (count != '0);
  assign pop       = ev_valid && ev_ready;
  assign full      = (count == CW'(FIFO_DEPTH));
  // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
  assign push_ok   = want_push && (!full || pop);
  assign drop      = want_push && full && !pop;

  assign head       = mem[rd_ptr];
  assign ev_x       = ev_valid ? head.x : 2'b00;
  assign ev_y       = ev_valid ? head.y : 2'b00;
  assign ev_p       = ev_valid ? head.p : 2'b00;
  assign ev_t       = ev_valid ? head.t : 2'b00;
  assign fifo_count = count;

  // Timestamp: t advances once every TS_DIV cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      ts      <= 2'b00;
    end else if (div_cnt == DW'(TS_DIV - 1)) begin
      div_cnt <= '0;
      ts      <= ts + 2'b01;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  // Per-pixel reference; first sample of a pixel only seeds it, dropped events leave it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_lvl <= '0;
      seen    <= '0;
    end else if (pix_valid) begin
      seen[idx] <= 1'b1;
      if (!seen[idx] || push_ok) begin
        ref_lvl[idx] <= pix_val;
      end
    end
  end

  // Storage needs no reset: outputs are gated by ev_valid.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= '{x: pix_x, y: pix_y, p: pol, t: ts};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Drop beats clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clear_ovf) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_event_stream_encoder.sv
// Bench for event_stream_encoder: directed scenarios plus randomized traffic
// checked against a queue-based reference model of the event rules.
module tb_event_stream_encoder;
  localparam int THRESH     = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int TS_DIV     = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pix_valid = 1'b0;
  logic [1:0] pix_x = '0;
  logic [1:0] pix_y = '0;
  logic [3:0] pix_val = '0;
  logic       ev_valid;
  logic       ev_ready = 1'b0;
  logic [1:0] ev_x, ev_y, ev_p, ev_t;
  logic [2:0] fifo_count;
  logic       overflow;
  logic       clear_ovf = 1'b0;

  int vecs = 0;
  int errs = 0;

  // Reference model state
  logic [3:0] m_ref [16];
  bit         m_seen [16];
  logic [7:0] m_q [$];
  bit         m_ovf;
  int         m_edges;

  event_stream_encoder #(
    .THRESH(4'(THRESH)), .FIFO_DEPTH(FIFO_DEPTH), .TS_DIV(TS_DIV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
    .pix_val(pix_val), .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_x(ev_x), .ev_y(ev_y),
    .ev_p(ev_p), .ev_t(ev_t), .fifo_count(fifo_count), .overflow(overflow),
    .clear_ovf(clear_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin
      m_ref[i]  = '0;
      m_seen[i] = 1'b0;
    end
    m_q.delete();
    m_ovf   = 1'b0;
    m_edges = 0;
  endtask

  // One clock edge: update the model from current inputs, then advance the DUT.
  task automatic step();
    bit pop, push, drop;
    int idx, d;
    logic [1:0] t, p;
    pop  = (m_q.size() > 0) && ev_ready;
    push = 1'b0;
    drop = 1'b0;
    p    = 2'b00;
    t    = 2'((m_edges / TS_DIV) % 4);
    if (pix_valid) begin
      idx = int'({pix_y, pix_x});
      if (!m_seen[idx]) begin
        m_seen[idx] = 1'b1;
        m_ref[idx]  = pix_val;
      end else begin
        d = int'(pix_val) - int'(m_ref[idx]);
        if (d >= THRESH) p = 2'b11;
        else if (-d >= THRESH) p = 2'b10;
        if (p != 2'b00) begin
          if (m_q.size() == FIFO_DEPTH && !pop) drop = 1'b1;
          else begin
            push = 1'b1;
            m_ref[idx] = pix_val;
          end
        end
      end
    end
    if (drop) m_ovf = 1'b1;
    else if (clear_ovf) m_ovf = 1'b0;
    if (pop) void'(m_q.pop_front());
    if (push) m_q.push_back({pix_x, pix_y, p, t});
    m_edges++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    pix_valid = 1'b0; pix_x = '0; pix_y = '0; pix_val = '0;
    ev_ready = 1'b0; clear_ovf = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_clear();
  endtask

  task automatic sample(input int x, input int y, input int v);
    pix_valid = 1'b1; pix_x = 2'(x); pix_y = 2'(y); pix_val = 4'(v);
    step();
    pix_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vecs++;
    if ({ev_valid, fifo_count, overflow, ev_x, ev_y, ev_p, ev_t} !== 13'd0) begin
      errs++;
      $display("FAIL reset_state: got valid=%0b cnt=%0d ovf=%0b x=%0d y=%0d p=%0d t=%0d, need all 0",
               ev_valid, fifo_count, overflow, ev_x, ev_y, ev_p, ev_t);
    end
  endtask

  task automatic test_first_event();
    ev_ready = 1'b0;
    sample(1, 2, 5);
    vecs++;
    if (ev_valid !== 1'b0 || fifo_count !== 3'd0) begin
      errs++;
      $display("FAIL seed_no_event: got valid=%0b cnt=%0d, need 0/0", ev_valid, fifo_count);
    end
    sample(1, 2, 7);
    vecs++;
    if ({ev_valid, ev_x, ev_y, ev_p} !== {1'b1, 2'd1, 2'd2, 2'b11}) begin
      errs++;
      $display("FAIL first_on_event: got valid=%0b x=%0d y=%0d p=%b, need 1/1/2/11",
               ev_valid, ev_x, ev_y, ev_p);
    end
  endtask

  task automatic test_threshold();
    ev_ready = 1'b1;
    step();                      // drain the ON event
    sample(1, 2, 6);
    vecs++;
    if (fifo_count !== 3'd0) begin
      errs++;
      $display("FAIL below_thresh: got cnt=%0d, need 0", fifo_count);
    end
    sample(1, 2, 5);
    vecs++;
    if ({ev_valid, ev_p, fifo_count} !== {1'b1, 2'b10, 3'd1}) begin
      errs++;
      $display("FAIL off_event: got valid=%0b p=%b cnt=%0d, need 1/10/1", ev_valid, ev_p, fifo_count);
    end
    sample(1, 2, 6);             // ref now 5: diff 1, no event; pop empties FIFO
    vecs++;
    if (fifo_count !== 3'd0) begin
      errs++;
      $display("FAIL ref_updated: got cnt=%0d, need 0", fifo_count);
    end
    sample(1, 2, 3);
    vecs++;
    if ({ev_valid, ev_p} !== {1'b1, 2'b10}) begin
      errs++;
      $display("FAIL off_from_new_ref: got valid=%0b p=%b, need 1/10", ev_valid, ev_p);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 5; i++) sample(i % 4, i / 4, 0);
    for (int i = 0; i < 5; i++) sample(i % 4, i / 4, 8);
    vecs++;
    if (fifo_count !== 3'd4 || overflow !== 1'b1) begin
      errs++;
      $display("FAIL overflow_set: got cnt=%0d ovf=%0b, need 4/1", fifo_count, overflow);
    end
    clear_ovf = 1'b1;
    sample(0, 1, 8);             // another drop in the same cycle as the clear
    vecs++;
    if (overflow !== 1'b1) begin
      errs++;
      $display("FAIL set_beats_clear: got ovf=%0b, need 1", overflow);
    end
    step();
    clear_ovf = 1'b0;
    vecs++;
    if (overflow !== 1'b0) begin
      errs++;
      $display("FAIL clear_ovf: got ovf=%0b, need 0", overflow);
    end
    ev_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vecs++;
      if ({ev_valid, ev_x, ev_y, ev_p} !== {1'b1, 2'(i), 2'd0, 2'b11}) begin
        errs++;
        $display("FAIL ovf_drain_%0d: got valid=%0b x=%0d y=%0d p=%b, need 1/%0d/0/11",
                 i, ev_valid, ev_x, ev_y, ev_p, i);
      end
      step();
    end
    sample(0, 1, 1);             // dropped pixel still has ref 0: diff 1, no event
    vecs++;
    if (fifo_count !== 3'd0) begin
      errs++;
      $display("FAIL dropped_ref_kept: got cnt=%0d, need 0", fifo_count);
    end
    sample(0, 1, 2);
    vecs++;
    if ({fifo_count, ev_p} !== {3'd1, 2'b11}) begin
      errs++;
      $display("FAIL dropped_pixel_event: got cnt=%0d p=%b, need 1/11", fifo_count, ev_p);
    end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    for (int i = 0; i < 5; i++) sample(i % 4, i / 4, 0);
    for (int i = 0; i < 4; i++) sample(i, 0, 9);
    ev_ready = 1'b1;
    sample(0, 1, 9);
    vecs++;
    if (fifo_count !== 3'd4 || overflow !== 1'b0) begin
      errs++;
      $display("FAIL full_push_pop: got cnt=%0d ovf=%0b, need 4/0", fifo_count, overflow);
    end
    for (int i = 1; i < 5; i++) begin
      vecs++;
      if ({ev_valid, ev_x, ev_y} !== {1'b1, 2'(i % 4), 2'(i / 4)}) begin
        errs++;
        $display("FAIL order_%0d: got valid=%0b x=%0d y=%0d, need 1/%0d/%0d",
                 i, ev_valid, ev_x, ev_y, i % 4, i / 4);
      end
      step();
    end
    vecs++;
    if (fifo_count !== 3'd0 || ev_valid !== 1'b0) begin
      errs++;
      $display("FAIL drained_empty: got cnt=%0d valid=%0b, need 0/0", fifo_count, ev_valid);
    end
  endtask

  task automatic test_timestamp();
    int edges [5] = '{0, 1, 9, 17, 33};
    int vals  [5] = '{0, 4, 0, 4, 0};
    logic [1:0] exp_t [5] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd0};
    int k = 0;
    do_reset();
    ev_ready = 1'b1;
    for (int e = 0; e <= 33; e++) begin
      if (k < 5 && edges[k] == e) begin
        sample(0, 0, vals[k]);
        if (k > 0) begin
          vecs++;
          if (ev_valid !== 1'b1 || ev_t !== exp_t[k]) begin
            errs++;
            $display("FAIL timestamp_edge%0d: got valid=%0b t=%0d, need 1/%0d",
                     e, ev_valid, ev_t, exp_t[k]);
          end
        end
        k++;
      end else begin
        step();
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] exp;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      pix_valid = ($urandom_range(0, 9) < 7);
      pix_x     = 2'($urandom_range(0, 1));
      pix_y     = 2'($urandom_range(0, 1));
      pix_val   = 4'($urandom_range(0, 15));
      ev_ready  = ($urandom_range(0, 1) == 1);
      clear_ovf = ($urandom_range(0, 9) == 0);
      step();
      exp = (m_q.size() > 0) ? m_q[0] : 8'd0;
      vecs++;
      if (ev_valid !== (m_q.size() > 0) || fifo_count !== 3'(m_q.size()) ||
          overflow !== m_ovf || {ev_x, ev_y, ev_p, ev_t} !== exp) begin
        errs++;
        $display("FAIL random_c%0d: got valid=%0b cnt=%0d ovf=%0b head=%h, need cnt=%0d ovf=%0b head=%h",
                 c, ev_valid, fifo_count, overflow, {ev_x, ev_y, ev_p, ev_t},
                 m_q.size(), m_ovf, exp);
      end
    end
    pix_valid = 1'b0; clear_ovf = 1'b0;
  endtask

  task automatic test_reset_midstream();
    do_reset();
    for (int i = 0; i < 3; i++) sample(i, 0, 0);
    for (int i = 0; i < 3; i++) sample(i, 0, 8);
    vecs++;
    if (fifo_count !== 3'd3) begin
      errs++;
      $display("FAIL queued_three: got cnt=%0d, need 3", fifo_count);
    end
    #2 rst_n = 1'b0;
    #1;
    vecs++;
    if (ev_valid !== 1'b0 || fifo_count !== 3'd0) begin
      errs++;
      $display("FAIL async_reset: got valid=%0b cnt=%0d, need 0/0", ev_valid, fifo_count);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    sample(0, 0, 8);
    vecs++;
    if (fifo_count !== 3'd0 || ev_valid !== 1'b0) begin
      errs++;
      $display("FAIL post_reset_seed: got cnt=%0d valid=%0b, need 0/0", fifo_count, ev_valid);
    end
    sample(0, 0, 0);
    vecs++;
    if ({fifo_count, ev_p} !== {3'd1, 2'b10}) begin
      errs++;
      $display("FAIL post_reset_event: got cnt=%0d p=%b, need 1/10", fifo_count, ev_p);
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_first_event();
    test_threshold();
    test_overflow();
    test_full_push_pop();
    test_timestamp();
    test_random();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
